// File: rtl/semaphore_pkg.sv
// Shared types and constants for the counting-semaphore client.
// Imported by the client FSM and its backoff/retry timer.
package semaphore_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_CHECK,
      ST_WRITE,
      ST_BACKOFF,
      ST_DONE
   } sem_state_t;

   localparam logic OP_ACQUIRE = 1'b0;
   localparam logic OP_RELEASE = 1'b1;

   localparam int unsigned SEM_CNT_W = 4;
   localparam logic [SEM_CNT_W-1:0] SEM_CNT_MAX = 4'd15;

endpackage

// File: rtl/semaphore_backoff_timer.sv
// Backoff down-counter plus acquire-retry counter for one semaphore client.
// The retry_last flag anticipates the increment so CHECK can decide in one cycle.
module semaphore_backoff_timer #(
   parameter int unsigned MaxRetries    = 15,
   parameter int unsigned BackoffCycles = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic clear_retry,
   input  logic inc_retry,
   output logic done,
   output logic retry_last
);

   logic [7:0] wait_cnt;
   logic [7:0] retry_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt  <= '0;
         retry_cnt <= '0;
      end else begin
         if (load)
            wait_cnt <= 8'(BackoffCycles);
         else if (wait_cnt != 8'd0)
            wait_cnt <= wait_cnt - 8'd1;

         if (clear_retry)
            retry_cnt <= '0;
         else if (inc_retry)
            retry_cnt <= retry_cnt + 8'd1;
      end
   end

   // Loaded on the CHECK edge, so BACKOFF spans BackoffCycles+1 cycles.
   assign done       = (wait_cnt == 8'd0);
   assign retry_last = ((9'(retry_cnt) + 9'd1) == 9'(MaxRetries));

endmodule

// File: rtl/semaphore_client.sv
// Per-core initiator for the shared counting semaphore: arbitrates via the
// blocking chain, reads the count, writes back count-1/count+1 and acknowledges.
module semaphore_client
   import semaphore_pkg::*;
#(
   parameter int unsigned MaxRetries    = 15,
   parameter int unsigned BackoffCycles = 4
) (
   input  logic                 CLK,
   input  logic                 SEMAPHORECLIENT_RESETn,
   input  logic                 SEMAPHORECLIENT_REQ,
   input  logic                 SEMAPHORECLIENT_OP,
   output logic                 SEMAPHORECLIENT_ACK,
   output logic                 SEMAPHORECLIENT_FAIL,
   output logic                 SEMAPHORECLIENT_BUSY,
   output logic                 SEMAPHORECLIENT_EN,
   input  logic                 SEMAPHORECLIENT_BLOCKING,
   input  logic [SEM_CNT_W-1:0] SEMAPHORECLIENT_CntIn,
   output logic [SEM_CNT_W-1:0] SEMAPHORECLIENT_CntOut,
   output logic                 SEMAPHORECLIENT_WR
);

   sem_state_t           state, state_d;
   logic                 op_r, op_d;
   logic                 fail_r, fail_d;
   logic [SEM_CNT_W-1:0] cnt_r, cnt_d;
   logic                 load_timer, clear_retry, inc_retry;
   logic                 timer_done, retry_last;

   semaphore_backoff_timer #(
      .MaxRetries    (MaxRetries),
      .BackoffCycles (BackoffCycles)
   ) u_timer (
      .clk         (CLK),
      .rst_n       (SEMAPHORECLIENT_RESETn),
      .load        (load_timer),
      .clear_retry (clear_retry),
      .inc_retry   (inc_retry),
      .done        (timer_done),
      .retry_last  (retry_last)
   );

   always_ff @(posedge CLK or negedge SEMAPHORECLIENT_RESETn) begin
      if (!SEMAPHORECLIENT_RESETn) begin
         state  <= ST_IDLE;
         op_r   <= OP_ACQUIRE;
         fail_r <= 1'b0;
         cnt_r  <= '0;
      end else begin
         state  <= state_d;
         op_r   <= op_d;
         fail_r <= fail_d;
         cnt_r  <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state;
      op_d        = op_r;
      fail_d      = fail_r;
      cnt_d       = cnt_r;
      load_timer  = 1'b0;
      clear_retry = 1'b0;
      inc_retry   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (SEMAPHORECLIENT_REQ) begin
               op_d        = SEMAPHORECLIENT_OP;
               clear_retry = 1'b1;
               state_d     = ST_ARB;
            end
         end
         ST_ARB: begin
            if (!SEMAPHORECLIENT_BLOCKING)
               state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (SEMAPHORECLIENT_BLOCKING) begin
               state_d = ST_ARB;
            end else if (op_r == OP_ACQUIRE && SEMAPHORECLIENT_CntIn == '0) begin
               inc_retry = 1'b1;
               if (retry_last) begin
                  fail_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  load_timer = 1'b1;
                  state_d    = ST_BACKOFF;
               end
            end else if (op_r == OP_RELEASE && SEMAPHORECLIENT_CntIn == SEM_CNT_MAX) begin
               fail_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d   = (op_r == OP_ACQUIRE) ? SEMAPHORECLIENT_CntIn - 4'd1
                                              : SEMAPHORECLIENT_CntIn + 4'd1;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (SEMAPHORECLIENT_BLOCKING) begin
               state_d = ST_ARB;
            end else begin
               fail_d  = 1'b0;
               state_d = ST_DONE;
            end
         end
         ST_BACKOFF: begin
            if (timer_done)
               state_d = ST_ARB;
         end
         ST_DONE: begin
            fail_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decode straight from the async-reset state so reset silences them at once.
   assign SEMAPHORECLIENT_EN     = (state == ST_ARB) || (state == ST_CHECK) || (state == ST_WRITE);
   assign SEMAPHORECLIENT_WR     = (state == ST_WRITE) && !SEMAPHORECLIENT_BLOCKING;
   assign SEMAPHORECLIENT_CntOut = SEMAPHORECLIENT_WR ? cnt_r : '0;
   assign SEMAPHORECLIENT_ACK    = (state == ST_DONE);
   assign SEMAPHORECLIENT_FAIL   = (state == ST_DONE) && fail_r;
   assign SEMAPHORECLIENT_BUSY   = (state != ST_IDLE);

endmodule

// File: tb/tb_semaphore_client.sv
// Directed bench: two clients sharing a modelled semaphore unit with a priority blocking chain.
module tb_semaphore_client;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0 = 1'b0, op0 = 1'b0, req1 = 1'b0, op1 = 1'b0;
   logic       force0 = 1'b0;
   logic       ack0, fail0, busy0, en0, wr0;
   logic       ack1, fail1, busy1, en1, wr1;
   logic [3:0] cnt_out0, cnt_out1;
   logic [3:0] count;
   logic       pre_en = 1'b0;
   logic [3:0] pre_val = 4'd0;
   logic       blk0, blk1;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   // Semaphore unit model: lower index wins, writes OR-combined.
   assign blk0 = force0;
   assign blk1 = en0;

   always_ff @(posedge clk) begin
      if (pre_en)
         count <= pre_val;
      else if (wr0 || wr1)
         count <= cnt_out0 | cnt_out1;
   end

   semaphore_client #(.MaxRetries(3), .BackoffCycles(2)) u_c0 (
      .CLK(clk), .SEMAPHORECLIENT_RESETn(rst_n),
      .SEMAPHORECLIENT_REQ(req0), .SEMAPHORECLIENT_OP(op0),
      .SEMAPHORECLIENT_ACK(ack0), .SEMAPHORECLIENT_FAIL(fail0),
      .SEMAPHORECLIENT_BUSY(busy0), .SEMAPHORECLIENT_EN(en0),
      .SEMAPHORECLIENT_BLOCKING(blk0), .SEMAPHORECLIENT_CntIn(count),
      .SEMAPHORECLIENT_CntOut(cnt_out0), .SEMAPHORECLIENT_WR(wr0)
   );

   semaphore_client #(.MaxRetries(3), .BackoffCycles(2)) u_c1 (
      .CLK(clk), .SEMAPHORECLIENT_RESETn(rst_n),
      .SEMAPHORECLIENT_REQ(req1), .SEMAPHORECLIENT_OP(op1),
      .SEMAPHORECLIENT_ACK(ack1), .SEMAPHORECLIENT_FAIL(fail1),
      .SEMAPHORECLIENT_BUSY(busy1), .SEMAPHORECLIENT_EN(en1),
      .SEMAPHORECLIENT_BLOCKING(blk1), .SEMAPHORECLIENT_CntIn(count),
      .SEMAPHORECLIENT_CntOut(cnt_out1), .SEMAPHORECLIENT_WR(wr1)
   );

   task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_count(input logic [3:0] v);
      pre_en  = 1'b1;
      pre_val = v;
      tick();
      pre_en  = 1'b0;
   endtask

   int en_low, wr_seen, ack_early;

   initial begin
      #2;
      check_eq("rst_en",   {7'd0, en0},   8'd0);
      check_eq("rst_wr",   {7'd0, wr0},   8'd0);
      check_eq("rst_cnt",  {4'd0, cnt_out0}, 8'd0);
      check_eq("rst_ack",  {7'd0, ack0},  8'd0);
      check_eq("rst_fail", {7'd0, fail0}, 8'd0);
      check_eq("rst_busy", {7'd0, busy0}, 8'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Release from 3, uncontended
      set_count(4'd3);
      req0 = 1'b1; op0 = 1'b1;                      // cycle t
      tick(); check_eq("rel_en_t1", {7'd0, en0}, 8'd1);
      check_eq("rel_busy_t1", {7'd0, busy0}, 8'd1);
      tick();
      tick(); check_eq("rel_wr_t3", {7'd0, wr0}, 8'd1);
      check_eq("rel_cnt_t3", {4'd0, cnt_out0}, 8'd4);
      tick(); check_eq("rel_ack_t4", {7'd0, ack0}, 8'd1);
      check_eq("rel_fail_t4", {7'd0, fail0}, 8'd0);
      check_eq("rel_count_t4", {4'd0, count}, 8'd4);
      req0 = 1'b0;
      tick(); check_eq("rel_idle", {7'd0, busy0}, 8'd0);

      // Acquire at 0: retries exhausted
      set_count(4'd0);
      req0 = 1'b1; op0 = 1'b0;
      en_low = 0; wr_seen = 0; ack_early = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (!en0) en_low++;
         if (wr0) wr_seen++;
         if (ack0) ack_early++;
      end
      tick();
      if (!en0) en_low++;
      check_eq("acq0_ack_t13", {7'd0, ack0}, 8'd1);
      check_eq("acq0_fail_t13", {7'd0, fail0}, 8'd1);
      check_eq("acq0_no_wr", 8'(wr_seen), 8'd0);
      check_eq("acq0_en_low", 8'(en_low), 8'd7);
      check_eq("acq0_no_early_ack", 8'(ack_early), 8'd0);
      req0 = 1'b0;
      tick();

      // Release at 15 fails without writing
      set_count(4'd15);
      req0 = 1'b1; op0 = 1'b1;
      wr_seen = 0;
      tick(); if (wr0) wr_seen++;
      tick(); if (wr0) wr_seen++;
      tick(); if (wr0) wr_seen++;
      check_eq("rel15_ack_t3", {7'd0, ack0}, 8'd1);
      check_eq("rel15_fail_t3", {7'd0, fail0}, 8'd1);
      check_eq("rel15_no_wr", 8'(wr_seen), 8'd0);
      check_eq("rel15_count", {4'd0, count}, 8'd15);
      req0 = 1'b0;
      tick();

      // Two clients acquire together from 2
      set_count(4'd2);
      req0 = 1'b1; op0 = 1'b0; req1 = 1'b1; op1 = 1'b0;
      tick(); check_eq("dual_c1_blk_t1", {7'd0, blk1}, 8'd1);
      tick();
      tick(); check_eq("dual_wr0_t3", {7'd0, wr0}, 8'd1);
      check_eq("dual_cnt0_t3", {4'd0, cnt_out0}, 8'd1);
      check_eq("dual_wr1_t3", {7'd0, wr1}, 8'd0);
      tick(); check_eq("dual_ack0_t4", {7'd0, ack0}, 8'd1);
      check_eq("dual_fail0_t4", {7'd0, fail0}, 8'd0);
      check_eq("dual_count_t4", {4'd0, count}, 8'd1);
      check_eq("dual_ack1_t4", {7'd0, ack1}, 8'd0);
      req0 = 1'b0;
      tick();
      tick(); check_eq("dual_wr1_t6", {7'd0, wr1}, 8'd1);
      check_eq("dual_cnt1_t6", {4'd0, cnt_out1}, 8'd0);
      tick(); check_eq("dual_ack1_t7", {7'd0, ack1}, 8'd1);
      check_eq("dual_fail1_t7", {7'd0, fail1}, 8'd0);
      check_eq("dual_count_t7", {4'd0, count}, 8'd0);
      req1 = 1'b0;
      tick();

      // Preemption during WRITE
      set_count(4'd5);
      req0 = 1'b1; op0 = 1'b0;
      tick(); tick(); tick();
      check_eq("pre_write_wr", {7'd0, wr0}, 8'd1);
      force0 = 1'b1; #1;
      check_eq("pre_forced_wr", {7'd0, wr0}, 8'd0);
      tick();
      check_eq("pre_arb_en", {7'd0, en0}, 8'd1);
      check_eq("pre_arb_ack", {7'd0, ack0}, 8'd0);
      check_eq("pre_count_kept", {4'd0, count}, 8'd5);
      force0 = 1'b0;
      tick(); tick();
      check_eq("pre_rewrite_wr", {7'd0, wr0}, 8'd1);
      check_eq("pre_rewrite_cnt", {4'd0, cnt_out0}, 8'd4);
      tick();
      check_eq("pre_ack", {7'd0, ack0}, 8'd1);
      check_eq("pre_fail", {7'd0, fail0}, 8'd0);
      check_eq("pre_count", {4'd0, count}, 8'd4);
      req0 = 1'b0;
      tick();

      // Reset asserted in WRITE
      set_count(4'd7);
      req0 = 1'b1; op0 = 1'b1;
      tick(); tick(); tick();
      check_eq("rstw_wr_before", {7'd0, wr0}, 8'd1);
      rst_n = 1'b0; #1;
      check_eq("rstw_wr", {7'd0, wr0}, 8'd0);
      check_eq("rstw_en", {7'd0, en0}, 8'd0);
      check_eq("rstw_busy", {7'd0, busy0}, 8'd0);
      req0 = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check_eq("rstw_idle", {7'd0, busy0}, 8'd0);
      check_eq("rstw_count", {4'd0, count}, 8'd7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/semaphore_client.md
# semaphore_client

Per-core initiator for the shared counting semaphore. Accepts acquire (P) and release (V) requests from one PLC core. For each request it:
- wins the priority blocking chain by asserting EN;
- reads the shared count;
- writes back count−1 or count+1 through the shared WR/CntIn port;
- acknowledges the core.

One instance sits between each core and the semaphore unit; its EN/BLOCKING pair occupies that core's slot in the blocking chain.

## Interface
Parameters:
- MaxRetries, 15: acquire attempts that see count==0 before the request fails; range 1..255.
- BackoffCycles, 4: idle cycles with EN deasserted between acquire attempts; range 1..255.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- SEMAPHORECLIENT_RESETn  in  1  asynchronous, active-low reset.
- SEMAPHORECLIENT_REQ  in  1  core request, level; held high until ACK.
- SEMAPHORECLIENT_OP  in  1  0 = acquire (−1), 1 = release (+1); sampled with REQ in IDLE.
- SEMAPHORECLIENT_ACK  out  1  one-cycle completion pulse.
- SEMAPHORECLIENT_FAIL  out  1  valid with ACK.
  - 1 = acquire retries exhausted, or release at count 15.
- SEMAPHORECLIENT_BUSY  out  1  high whenever state ≠ IDLE.
- SEMAPHORECLIENT_EN  out  1  to the semaphore unit EN bit for this core.
- SEMAPHORECLIENT_BLOCKING  in  1  from the semaphore unit BLOCKING bit for this core.
- SEMAPHORECLIENT_CntIn  in  4  current shared count (semaphore unit CntOut).
- SEMAPHORECLIENT_CntOut  out  4  new count; 4'd0 whenever WR=0, so clients can be OR-combined.
- SEMAPHORECLIENT_WR  out  1  write strobe; OR-combined across clients into the unit WR.

## Operation
States: IDLE, ARB, CHECK, WRITE, BACKOFF, DONE.
- **IDLE**
  - EN=0.
  - REQ=1 → latch OP, clear retry count, go to ARB.
- **ARB**
  - EN=1.
  - BLOCKING=0 → CHECK; otherwise stay in ARB, with no timeout.
- **CHECK**
  - EN=1; evaluate in priority order:
    - BLOCKING=1 → ARB (preempted by a lower-index core).
    - Acquire with CntIn==0 → retry count +1. If it now equals MaxRetries → DONE with FAIL=1; otherwise → BACKOFF.
    - Release with CntIn==15 → DONE with FAIL=1; no write.
    - Otherwise latch the new value (CntIn−1 or CntIn+1, 4-bit, never wrapping) → WRITE.
- **WRITE**
  - EN=1.
  - WR = ~BLOCKING, combinational from state; CntOut = latched value when WR=1.
  - BLOCKING=1 → ARB with no write; otherwise → DONE with FAIL=0.
- **BACKOFF**
  - EN=0; count BackoffCycles cycles, then → ARB.
- **DONE**
  - EN=0, ACK=1, FAIL as decided; → IDLE.
- Request handshake:
  - REQ still high in the IDLE cycle after ACK is treated as a new request.
  - OP changes while BUSY are ignored.
- Preemption aborts (CHECK/WRITE → ARB) do not consume retries.

## Timing
- Reset (asynchronous assert) gives, immediately:
  - state IDLE;
  - EN=0, WR=0, CntOut=0, ACK=0, FAIL=0, BUSY=0;
  - retry and backoff counters cleared.
- Reset mid-WRITE drops WR in the same instant, so no write occurs on the next edge. Deassertion takes effect at the next CLK edge.
- Best case, REQ first seen high in IDLE at cycle t:
  - t+1 ARB (EN=1);
  - t+2 CHECK;
  - t+3 WRITE (WR=1);
  - t+4 DONE (ACK=1); CntIn shows the new value in this cycle.
- Failed acquire, zero contention: (MaxRetries−1)×(2 + BackoffCycles + 1) + 3 cycles from REQ to ACK.
- EN is held continuously from ARB through WRITE. This keeps higher-index cores blocked for the whole read-modify-write.

## Structure
- Shared package semaphore_pkg:
  - state encoding localparams;
  - OP_ACQUIRE=1'b0, OP_RELEASE=1'b1;
  - SEM_CNT_W=4, SEM_CNT_MAX=4'd15.
- One sub-module, semaphore_backoff_timer:
  - loadable down-counter of BackoffCycles;
  - outputs a done flag;
  - also holds the retry counter with a MaxRetries compare.
- FSM, value latch and output gating stay in semaphore_client.

## Test plan
- Release, count 3, no contention:
  - REQ=1, OP=1 → WR=1 with CntOut=4 at t+3;
  - ACK=1, FAIL=0 at t+4; unit count reads 4.
- Acquire, count 0, MaxRetries=3, BackoffCycles=2:
  - no WR ever;
  - EN toggles 0 in each BACKOFF;
  - ACK with FAIL=1 at t+13.
- Release, count 15 → no WR; ACK+FAIL=1 at t+3.
- Two clients (index 0 and 1) on one semaphore unit, count 2, both acquire in the same cycle:
  - core 0 writes 1 first;
  - core 1 stays in ARB while core 0's EN is high, then writes 0;
  - both ACK with FAIL=0.
- Preemption in WRITE:
  - force BLOCKING=1 during client's WRITE cycle → WR stays 0, state returns to ARB;
  - the write completes once BLOCKING clears; retry count unchanged.
- Reset mid-operation:
  - RESETn=0 during WRITE → WR, EN and BUSY are 0 immediately;
  - after release, IDLE; the unit count is unchanged.
